fir_tx_packetizer: RTL and testbench

- Buffers filtered FIR output samples and sends them to the PC as framed 4-byte UART packets.
- Sits between the FIR filter output (y_out plus a one-cycle sample strobe) and the byte-level uart_tx instance.
- Saturates the wide filter result to 16 bits and absorbs bursts in a FIFO, so samples are not lost while the UART is busy.
- Counts dropped samples for debug.

---
 rtl/fir_tx_packetizer.sv | 184 ++++++++++++++++++
 tb/tb_fir_tx_packetizer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tx_packetizer.sv
// fir_tx_packetizer
//   Takes FIR output samples, saturates them to 16 bits, buffers them in a FIFO and sends
//   each one to the PC as a 4-byte frame through a byte-level UART transmitter:
//     SYNC_BYTE, word[15:8], word[7:0], word[15:8] ^ word[7:0]
//   Samples that arrive while the FIFO is full (and no pop frees a slot) are dropped and
//   counted.
//
// Ports
//   clk         system clock
//   rstn        asynchronous active-low reset
//   in_valid    one-cycle strobe, in_data holds a new sample
//   in_data     signed filter output sample (IN_WIDTH bits)
//   tx_ready    UART transmitter idle, can accept a byte
//   tx_start    one-cycle pulse launching tx_data
//   tx_data     byte to transmit, holds its value between pulses
//   fifo_level  words currently buffered
//   drop_pulse  one-cycle pulse when a sample is discarded
//   drop_cnt    total dropped samples, saturating at 16'hFFFF
module fir_tx_packetizer #(
   parameter int unsigned IN_WIDTH  = 20,
   parameter int unsigned DEPTH     = 16,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        in_valid,
   input  logic signed [IN_WIDTH-1:0]  in_data,
   input  logic                        tx_ready,
   output logic                        tx_start,
   output logic [7:0]                  tx_data,
   output logic [$clog2(DEPTH):0]      fifo_level,
   output logic                        drop_pulse,
   output logic [15:0]                 drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic signed [IN_WIDTH-1:0] SAT_MAX    = IN_WIDTH'(32767);
   localparam logic signed [IN_WIDTH-1:0] SAT_MIN    = IN_WIDTH'(-32768);
   localparam logic [AW:0]                FULL_LEVEL = (AW+1)'(DEPTH);
   localparam logic [AW:0]                LEVEL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]              PTR_ONE    = AW'(1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   // FIFO storage and bookkeeping
   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;

   // Framing FSM
   logic [1:0]    state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   hold_q, hold_d;
   logic          tx_start_q, tx_start_d;
   logic [7:0]    tx_data_q, tx_data_d;

   logic          drop_pulse_q;
   logic [15:0]   drop_cnt_q;

   logic [15:0]   sat_word;
   logic [7:0]    issue_byte;
   logic          fifo_empty, fifo_full, pop, wr_ok, drop;

   always_comb begin
      if (in_data > SAT_MAX) begin
         sat_word = 16'h7FFF;
      end else if (in_data < SAT_MIN) begin
         sat_word = 16'h8000;
      end else begin
         sat_word = in_data[15:0];
      end
   end

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_LEVEL);

   // The sync byte does not depend on the word, so the pop and the launch of byte 0 share
   // one cycle; this is why popping waits for tx_ready.
   assign pop   = (state_q == ST_IDLE) && !fifo_empty && tx_ready;
   assign wr_ok = in_valid && (!fifo_full || pop);
   assign drop  = in_valid && !wr_ok;

   always_comb begin
      unique case (idx_q)
         2'd0:    issue_byte = SYNC_BYTE;
         2'd1:    issue_byte = hold_q[15:8];
         2'd2:    issue_byte = hold_q[7:0];
         default: issue_byte = hold_q[15:8] ^ hold_q[7:0];
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (wr_ok && !pop) begin
         count_d = count_q + LEVEL_ONE;
      end else if (pop && !wr_ok) begin
         count_d = count_q - LEVEL_ONE;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               hold_d     = mem[rd_ptr_q];
               idx_d      = 2'd0;
               tx_start_d = 1'b1;
               tx_data_d  = SYNC_BYTE;
               state_d    = ST_GAP;
            end
         end
         ST_ISSUE: begin
            if (tx_ready) begin
               tx_start_d = 1'b1;
               tx_data_d  = issue_byte;
               state_d    = ST_GAP;
            end
         end
         ST_GAP: begin
            // tx_ready is ignored here: the UART needs a cycle to drop it after a start.
            if (idx_q == 2'd3) begin
               state_d = ST_IDLE;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = ST_ISSUE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_q] <= sat_word;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         state_q      <= ST_IDLE;
         idx_q        <= 2'd0;
         hold_q       <= 16'h0000;
         tx_start_q   <= 1'b0;
         tx_data_q    <= 8'h00;
         drop_pulse_q <= 1'b0;
         drop_cnt_q   <= 16'h0000;
      end else begin
         if (wr_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         count_q      <= count_d;
         state_q      <= state_d;
         idx_q        <= idx_d;
         hold_q       <= hold_d;
         tx_start_q   <= tx_start_d;
         tx_data_q    <= tx_data_d;
         drop_pulse_q <= drop;
         if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign fifo_level = count_q;
   assign drop_pulse = drop_pulse_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_fir_tx_packetizer.sv
// Testbench for fir_tx_packetizer: directed stimulus, a frame-level byte model and a
// per-cycle monitor checking every tx_start against the model, plus literal expectations.
module tb_fir_tx_packetizer;

   localparam int unsigned IN_WIDTH = 20;
   localparam int unsigned DEPTH    = 16;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic [19:0] in_data;
   logic        tx_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic [4:0]  fifo_level;
   logic        drop_pulse;
   logic [15:0] drop_cnt;

   fir_tx_packetizer #(
      .IN_WIDTH  (IN_WIDTH),
      .DEPTH     (DEPTH),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .tx_ready   (tx_ready),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .fifo_level (fifo_level),
      .drop_pulse (drop_pulse),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q[$];   // bytes the model says must still be sent, in order
   logic [7:0] got_q[$];   // bytes observed on tx_start
   int         got_cyc[$];

   int   drops_seen = 0;
   int   last_cyc   = 0;
   bit   have_last  = 0;
   logic rdy_prev   = 1'b0;
   int   n_strobe;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: saturate to 16 bits and expand into the 4-byte frame.
   function automatic logic [15:0] sat16(input int v);
      int w;
      if (v > 32767) return 16'h7FFF;
      if (v < -32768) return 16'h8000;
      w = v & 32'hFFFF;
      return w[15:0];
   endfunction

   task automatic push_frame(input logic [19:0] d);
      logic [15:0] w;
      w = sat16(int'($signed(d)));
      exp_q.push_back(8'hA5);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8] ^ w[7:0]);
   endtask

   // Monitor: every launched byte must match the model, be at least 2 cycles after the
   // previous one, and follow a cycle in which tx_ready was high.
   always @(negedge clk) begin
      if (!rstn) begin
         have_last  = 0;
         drops_seen = 0;
      end else begin
         if (tx_start) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_tx_start: got data 0x%0h, expected no start (cycle %0d)",
                        tx_data, cyc);
            end else begin
               check("tx_data", tx_data, exp_q.pop_front());
            end
            if (have_last) check("tx_start_spacing", (cyc - last_cyc >= 2) ? 1 : 0, 1);
            check("tx_ready_before_start", rdy_prev, 1);
            got_q.push_back(tx_data);
            got_cyc.push_back(cyc);
            last_cyc  = cyc;
            have_last = 1;
         end
         if (drop_pulse) drops_seen++;
         check("drop_cnt_track", drop_cnt, drops_seen);
      end
      rdy_prev = tx_ready;
   end

   task automatic send(input logic [19:0] d);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      n_strobe = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d bytes pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input string name, input int base, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
      check(name, (got_q.size() > base)     ? got_q[base]     : -1, b0);
      check(name, (got_q.size() > base + 1) ? got_q[base + 1] : -1, b1);
      check(name, (got_q.size() > base + 2) ? got_q[base + 2] : -1, b2);
      check(name, (got_q.size() > base + 3) ? got_q[base + 3] : -1, b3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int sz;
      rstn     = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_drop_pulse", drop_pulse, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (2) @(posedge clk);

      // Single sample: latency and spacing.
      got_q.delete();
      got_cyc.delete();
      push_frame(20'h01234);
      send(20'h01234);
      @(negedge clk);
      check("single_fifo_level", fifo_level, 1);
      wait_drain(100);
      check("single_nbytes", got_q.size(), 4);
      check_frame("single_bytes", 0, 8'hA5, 8'h12, 8'h34, 8'h26);
      if (got_cyc.size() == 4) begin
         check("single_first_latency", got_cyc[0] - n_strobe, 2);
         for (int k = 0; k < 3; k++) check("single_spacing", got_cyc[k+1] - got_cyc[k], 2);
      end
      check("single_level_end", fifo_level, 0);

      // Saturation, three samples queued back to back.
      got_q.delete();
      got_cyc.delete();
      push_frame(20'h12345);
      push_frame(20'hF0000);
      push_frame(20'hFFFFF);
      send(20'h12345);
      send(20'hF0000);
      send(20'hFFFFF);
      wait_drain(200);
      check("sat_nbytes", got_q.size(), 12);
      check_frame("sat_pos", 0, 8'hA5, 8'h7F, 8'hFF, 8'h80);
      check_frame("sat_neg", 4, 8'hA5, 8'h80, 8'h00, 8'h80);
      check_frame("sat_m1", 8, 8'hA5, 8'hFF, 8'hFF, 8'h00);
      if (got_cyc.size() == 12) check("inter_frame_gap", got_cyc[4] - got_cyc[3], 2);

      // Backpressure after the sync byte, with a new sample arriving meanwhile.
      got_q.delete();
      got_cyc.delete();
      push_frame(20'h00ABC);
      send(20'h00ABC);
      n = 0;
      while (got_q.size() == 0 && !tx_start && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      tx_ready = 1'b0;
      push_frame(20'h00123);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         in_valid = (i == 10);
         in_data  = 20'h00123;
      end
      check("bp_no_start", got_q.size(), 1);
      check("bp_fifo_level", fifo_level, 1);
      tx_ready = 1'b1;
      wait_drain(200);
      check("bp_nbytes", got_q.size(), 8);
      check_frame("bp_first", 0, 8'hA5, 8'h0A, 8'hBC, 8'hB6);
      check_frame("bp_second", 4, 8'hA5, 8'h01, 8'h23, 8'h22);
      if (got_cyc.size() == 8) check("bp_stall_len", (got_cyc[1] - got_cyc[0] >= 50) ? 1 : 0, 1);

      // Overflow: 19 samples with the UART stalled, then full FIFO plus same-cycle pop.
      got_q.delete();
      got_cyc.delete();
      @(posedge clk); #1;
      tx_ready = 1'b0;
      for (int i = 0; i < 19; i++) begin
         @(posedge clk); #1;
         if (i >= 1) check("ovf_drop_pulse", drop_pulse, (i - 1 >= 16) ? 1 : 0);
         in_valid = 1'b1;
         in_data  = 20'(i);
         if (i < 16) push_frame(20'(i));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("ovf_drop_last", drop_pulse, 1);
      @(posedge clk); #1;
      check("ovf_fifo_level", fifo_level, 16);
      check("ovf_drop_cnt", drop_cnt, 3);
      check("ovf_no_start", got_q.size(), 0);
      tx_ready = 1'b1;
      in_valid = 1'b1;
      in_data  = 20'd100;
      push_frame(20'd100);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("fullpop_level", fifo_level, 16);
      check("fullpop_drop_pulse", drop_pulse, 0);
      check("fullpop_drop_cnt", drop_cnt, 3);
      wait_drain(400);
      check("ovf_nbytes", got_q.size(), 68);
      for (int k = 0; k < 16; k++) begin
         check_frame("ovf_frame", 4 * k, 8'hA5, 8'h00, 8'(k), 8'(k));
      end
      check_frame("fullpop_frame", 64, 8'hA5, 8'h00, 8'h64, 8'h64);
      check("ovf_level_end", fifo_level, 0);

      // Reset mid-frame with a second sample still buffered.
      got_q.delete();
      got_cyc.delete();
      push_frame(20'h05555);
      send(20'h05555);
      send(20'h06666);
      n = 0;
      while (got_q.size() < 2 && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check("rst_mid_bytes_before", got_q.size(), 2);
      rstn = 1'b0;
      exp_q.delete();
      #1;
      check("rst_mid_tx_start", tx_start, 0);
      check("rst_mid_tx_data", tx_data, 0);
      check("rst_mid_fifo_level", fifo_level, 0);
      check("rst_mid_drop_cnt", drop_cnt, 0);
      check("rst_mid_drop_pulse", drop_pulse, 0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      sz = got_q.size();
      repeat (30) @(posedge clk);
      #1;
      check("rst_mid_quiet", got_q.size(), sz);
      check("rst_mid_level_after", fifo_level, 0);
      push_frame(20'h00042);
      send(20'h00042);
      wait_drain(100);
      check("rst_new_nbytes", got_q.size(), sz + 4);
      check_frame("rst_new_frame", sz, 8'hA5, 8'h00, 8'h42, 8'h42);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
